// File: rtl/control_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, instruction
// encodings, ALU operation codes and the operand/PC mux encodings that the
// datapath muxes decode as well.
package control_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_FWAIT,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_R,
    S_WB_I,
    S_MADDR,
    S_LRD,
    S_LWAIT,
    S_LWB,
    S_SWR,
    S_BRANCH,
    S_JUMP,
    S_EXC
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  // A wait state spends its last cycle when the counter is at 1; treating 0
  // the same way keeps an out-of-range zero wait from wrapping to 7.
  function automatic logic wait_last(input logic [2:0] wcnt);
    return (wcnt <= 3'd1);
  endfunction

endpackage

// File: rtl/control_alu_dec.sv
// ALU operation decoder: chooses the ALU operation for the current state and
// reports whether an R-type funct field is one the machine implements.
module control_alu_dec
  import control_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       funct_valid
);

  logic [2:0] rtype_op;

  // Map the R-type funct field onto an ALU code and flag unsupported functs.
  always_comb begin
    rtype_op    = ALU_NONE;
    funct_valid = 1'b0;
    case (funct)
      FN_ADD: begin rtype_op = ALU_ADD; funct_valid = 1'b1; end
      FN_SUB: begin rtype_op = ALU_SUB; funct_valid = 1'b1; end
      FN_AND: begin rtype_op = ALU_AND; funct_valid = 1'b1; end
      default: ;
    endcase
  end

  // Address/PC arithmetic adds, branch compares subtract, R-type follows funct.
  always_comb begin
    alu_op = ALU_NONE;
    case (state)
      S_FETCH, S_DECODE, S_EXEC_I, S_MADDR: alu_op = ALU_ADD;
      S_EXEC_R:                             alu_op = rtype_op;
      S_BRANCH:                             alu_op = ALU_SUB;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM. Outputs are a pure function of the registered state
// (including the memory wait counter), so the datapath sees glitch-free,
// cycle-aligned control for every step of each instruction.
module control_unit
  import control_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       shift_imm,
  output logic [2:0] alu_op,
  output logic       alu_out_write,
  output logic [1:0] pc_source,
  output logic       epc_write
);

  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);

  state_t     state, state_next;
  logic [2:0] wcnt, wcnt_next;
  logic       funct_valid;

  // The branch decision on zero is made by the datapath through pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  control_alu_dec u_alu_dec (
    .state       (state),
    .funct       (funct),
    .alu_op      (alu_op),
    .funct_valid (funct_valid)
  );

  // State and wait counter registers; reset aborts any instruction at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RESET;
      wcnt  <= 3'd0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
    end
  end

  // Next state and wait counter; the counter is loaded when entering a wait
  // state and counts down while the memory access is outstanding.
  always_comb begin
    state_next = state;
    wcnt_next  = 3'd0;
    case (state)
      S_RESET:  state_next = S_FETCH;
      S_FETCH: begin
        state_next = S_FWAIT;
        wcnt_next  = WAIT_LOAD;
      end
      S_FWAIT: begin
        if (wait_last(wcnt)) state_next = S_DECODE;
        else                 wcnt_next  = wcnt - 3'd1;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = funct_valid ? S_EXEC_R : S_FETCH;
          OP_ADDI:      state_next = S_EXEC_I;
          OP_LW, OP_SW: state_next = S_MADDR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_EXEC_R: state_next = (overflow && (funct != FN_AND)) ? S_EXC : S_WB_R;
      S_EXEC_I: state_next = overflow ? S_EXC : S_WB_I;
      S_MADDR:  state_next = (opcode == OP_SW) ? S_SWR : S_LRD;
      S_LRD: begin
        state_next = S_LWAIT;
        wcnt_next  = WAIT_LOAD;
      end
      S_LWAIT: begin
        if (wait_last(wcnt)) state_next = S_LWB;
        else                 wcnt_next  = wcnt - 3'd1;
      end
      S_WB_R, S_WB_I, S_LWB, S_SWR, S_BRANCH, S_JUMP, S_EXC:
        state_next = S_FETCH;
      default: state_next = S_RESET;
    endcase
  end

  // Moore output decode; every control defaults to inactive.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    shift_imm     = 1'b0;
    alu_out_write = 1'b0;
    pc_source     = PCSRC_ALU;
    epc_write     = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b = SRCB_4;
        pc_write  = 1'b1;
      end
      S_FWAIT:  ir_write = wait_last(wcnt);
      S_DECODE: begin
        alu_src_b     = SRCB_IMM;
        shift_imm     = 1'b1;
        alu_out_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a     = 1'b1;
        alu_out_write = 1'b1;
      end
      S_EXEC_I, S_MADDR: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_IMM;
        alu_out_write = 1'b1;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_WB_I:   reg_write = 1'b1;
      S_LRD, S_LWAIT: iord = 1'b1;
      S_LWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_SWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
      end
      S_EXC: begin
        epc_write = 1'b1;
        pc_source = PCSRC_EXC;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
